rand_rot_seq: RTL
=================

RAND_ROT_SEQ -- requirements
Module: rand_rot_seq

Interface
- REQ-001 SHALL have parameter WIDTH, default 139: randomness vector width in bits.
- REQ-002 SHALL have parameter STEP, default 8: rotation step in bits per output beat.
- REQ-003 SHALL have parameter NROT, default 15: number of rotations served per loaded vector, giving NROT+1 beats.
- REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
- REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
- REQ-006 SHALL have port flush, input, 1 bit: synchronous abort and zeroize.
- REQ-007 SHALL have port in_valid, input, 1 bit: fresh randomness offered.
- REQ-008 SHALL have port in_ready, output, 1 bit: block accepts fresh randomness.
- REQ-009 SHALL have port in_data, input, WIDTH bits: fresh randomness vector.
- REQ-010 SHALL have port out_valid, output, 1 bit: out_data holds a valid rotated vector.
- REQ-011 SHALL have port out_ready, input, 1 bit: consumer takes the current beat.
- REQ-012 SHALL have port out_data, output, WIDTH bits: current rotated vector.
- REQ-013 SHALL have port out_idx, output, 4 bits: rotation index k of the current beat, 0..NROT.
- REQ-014 SHALL have port refill_req, output, 1 bit: the last beat of the held vector is being presented.

Function
- REQ-015 SHALL implement two states, IDLE and SERVE, plus a WIDTH-bit vector register and a 4-bit index counter.
- REQ-016 SHALL transfer input when in_valid and in_ready are both high on a rising clk edge, and output when out_valid and out_ready are both high.
- REQ-017 SHALL, in IDLE, drive in_ready=1, out_valid=0, out_data=0 and out_idx=0.
- REQ-018 SHALL, on an input transfer, load the register with in_data, set idx=0 and enter SERVE; out_valid rises on the next cycle (1-cycle latency).
- REQ-019 SHALL, in SERVE, drive out_valid=1, out_data=register and out_idx=idx; out_data at index k equals in_data rotated right by k*STEP bits, i.e. {in_data[k*STEP-1:0], in_data[WIDTH-1:k*STEP]}.
- REQ-020 SHALL, on an output transfer with idx<NROT, rotate the register right by STEP bits and increment idx.
- REQ-021 SHALL, on an output transfer with idx==NROT, clear the register to 0 and return to IDLE, unless an input transfer occurs in the same cycle.
- REQ-022 SHALL, in SERVE with idx==NROT, drive refill_req=1; in_ready=(IDLE) or (SERVE and idx==NROT and out_ready), a combinational path from out_ready.
- REQ-023 SHALL, when an input transfer coincides with the final output transfer, load the new vector with idx=0 and stay in SERVE, giving back-to-back beats with no bubble.
- REQ-024 SHALL hold out_data and out_idx stable while out_valid=1 and out_ready=0 (stall); the register SHALL not rotate.
- REQ-025 SHALL never present the same (vector, idx) beat twice; idx SHALL not wrap past NROT.
- REQ-026 SHALL, when flush=1, return to IDLE, clear the register and idx, and ignore any simultaneous transfers; flush SHALL take priority over all other events.
- REQ-027 SHALL require WIDTH > NROT*STEP; behaviour is undefined otherwise.

Reset
- REQ-028 SHALL, while rst_n=0, immediately force IDLE, register=0, idx=0, out_valid=0, out_data=0, out_idx=0, refill_req=0 and in_ready=0; in_ready=1 from the first clk edge after release.
- REQ-029 SHALL discard the held vector on reset asserted mid-SERVE; no partial beat appears after release.

Verification
- REQ-030 SHALL cover: load in_data=139'h1, out_ready=1 constant -> 16 beats with idx 0..15; beat k has only bit (139-8k) mod 139 set (k=1: bit 131; k=15: bit 19); refill_req=1 only on beat 15; then IDLE with out_data=0.
- REQ-031 SHALL cover: in_valid held high with a second vector 139'h3 -> beat 15 of the first vector is followed next cycle by idx=0, out_data=139'h3, with no out_valid gap.
- REQ-032 SHALL cover: out_ready=0 for 5 cycles at idx=7 -> out_data and out_idx frozen at 7; the rotation resumes correctly afterwards.
- REQ-033 SHALL cover: flush=1 at idx=4 together with out_ready=1 and in_valid=1 -> next cycle IDLE, out_valid=0, out_data=0; the new vector is not loaded.
- REQ-034 SHALL cover: rst_n pulsed low asynchronously mid-cycle at idx=9 -> outputs zero immediately; after release, in_ready=1 and out_valid=0 until a new load.
- REQ-035 SHALL cover: a random in_data with random out_ready stalls -> every beat matches a reference rotate-right by 8k bits, and exactly 16 beats are produced per load.

Source files
------------

// File: rtl/rand_rot_seq.sv
// Serves NROT+1 right-rotations (STEP bits apart) of each loaded randomness vector.
// First beat one cycle after load; beats hold on out_ready=0; a refill is accepted on the final beat.
module rand_rot_seq #(
  parameter int WIDTH = 139,
  parameter int STEP  = 8,
  parameter int NROT  = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       out_idx,
  output logic             refill_req
);

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;

  localparam logic [3:0] LAST_IDX = 4'(NROT);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] vec_q, vec_d;
  logic [3:0]       idx_q, idx_d;
  logic             live_q, live_d;

  logic             serving;
  logic             on_last;
  logic             in_xfer;
  logic             out_xfer;
  logic [WIDTH-1:0] vec_rot;

  assign serving  = (state_q == SERVE);
  assign on_last  = serving && (idx_q == LAST_IDX);
  assign vec_rot  = {vec_q[STEP-1:0], vec_q[WIDTH-1:STEP]};

  // live_q keeps in_ready low while in reset and until the first edge after release.
  assign in_ready   = live_q && (!serving || (on_last && out_ready));
  assign out_valid  = serving;
  assign out_data   = serving ? vec_q : '0;
  assign out_idx    = serving ? idx_q : 4'd0;
  assign refill_req = on_last;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    idx_d   = idx_q;
    live_d  = 1'b1;
    if (flush) begin
      state_d = IDLE;
      vec_d   = '0;
      idx_d   = 4'd0;
    end else if (in_xfer) begin
      // Covers both the IDLE load and the back-to-back refill on the final beat.
      state_d = SERVE;
      vec_d   = in_data;
      idx_d   = 4'd0;
    end else if (out_xfer) begin
      if (idx_q < LAST_IDX) begin
        vec_d = vec_rot;
        idx_d = idx_q + 4'd1;
      end else begin
        state_d = IDLE;
        vec_d   = '0;
        idx_d   = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      idx_q   <= 4'd0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      idx_q   <= idx_d;
      live_q  <= live_d;
    end
  end

endmodule
